dps_dec_arb: RTL and testbench
==============================

Name: dps_dec_arb

Overview:
- Shares one 29-bit DPS (Fibonacci-numeral-system) codeword decoder between NCH receive channels of a CAC link.
- Each channel offers a 29-bit codeword with a valid/ready handshake. A round-robin arbiter grants one channel per cycle.
- The decoded binary word leaves through a 2-stage elastic pipeline, tagged with its source channel.
- Sits between the link receivers and the data sink. It replaces per-channel decoder instances.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- CW, 29, codeword width; fixed at 29 for this block.
- DW, 21, decoded data width; must equal the `DBLEN29 width from FNS.vh.
- CHW, $clog2(NCH), channel-tag width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_code  in  NCH*CW  codewords; channel k occupies bits [k*CW +: CW].
- in_valid  in  NCH  per-channel codeword valid.
- in_ready  out  NCH  per-channel accept; at most one bit high per cycle.
- out_data  out  DW  decoded value.
- out_ch  out  CHW  source channel of out_data.
- out_valid  out  1  output valid.
- out_ready  in  1  sink accept.
- out_err  out  1  forbidden-pattern flag, qualified by out_valid (see Optional Feature).
- acc_cnt  out  16  count of accepted codewords, wraps modulo 2^16.

Behaviour:
- Reset (rst=1 at a clk edge):
  - s1_v=0, s2_v=0 (out_valid=0).
  - out_data=0, out_ch=0, out_err=0.
  - rr_ptr=0, acc_cnt=0.
  - in_ready=0 during the reset cycle.
  - Reset mid-operation discards both pipeline entries. No partial output is produced.
- Pipeline, two registers:
  - S1 holds code_q and ch_q.
  - S2 holds out_data, out_ch and out_err.
  - adv2 = !s2_v || out_ready.
  - adv1 = !s1_v || adv2.
- Arbitration:
  - When adv1=1 and any in_valid is set, the grant g is the first channel with in_valid=1, searching rr_ptr, rr_ptr+1, … mod NCH.
  - in_ready[g]=1 combinationally; all other in_ready bits are 0.
  - If adv1=0, all in_ready are 0.
  - in_ready does not depend on out_ready except through adv1/adv2.
  - On a grant: code_q<=in_code[g], ch_q<=g, s1_v<=1, rr_ptr<=(g+1) mod NCH, acc_cnt<=acc_cnt+1.
  - No grant with adv1=1: s1_v<=0, and rr_ptr is unchanged.
- Decode:
  - Combinational over code_q: dataout = Σ code_q[i]*W[i].
  - W[i]=`FNS(i+1) for i=0..26; W[27]=2*`FNS28; W[28]=`FNS29.
  - The sum is computed at DW bits with no truncation; the weights guarantee it fits.
- S2 load when adv2=1: s2_v<=s1_v.
  - If s1_v=1: out_data<=decode, out_ch<=ch_q, out_err<=chk.
  - If s1_v=0: out_data, out_ch and out_err hold.
- Latency: accept at edge T, out_valid=1 after edge T+1. This is 2 cycles with out_ready held high.
- Throughput: 1 codeword/cycle sustained.
- Backpressure: out_valid=1 with out_ready=0 holds out_data, out_ch and out_err stable.
  - S1 also holds if occupied; once S1 is full, no grant is made.
  - Codewords are never dropped or duplicated.
- Simultaneous drain-and-fill of S1/S2 in the same cycle is legal and required for full throughput.
- in_code of an ungranted channel is ignored.
- A channel may drop in_valid without a handshake; the arbiter treats this as no request.

Optional Feature:
- Macro DPS_DEC_FPCHK_EN.
- Defined: chk=1 when code_q contains an adjacent pattern 010 or 101 at any bit triple [i+2:i], i=0..26. out_err carries chk with the word; decoding still proceeds.
- Undefined: chk logic is absent and out_err is tied to 0.

Decomposition:
- Package dps_pkg: CW, DW, the FNS weight constants W[0..28] built from FNS.vh, and a function fns_decode(code) returning DW bits.
- One sub-module: rr_arb_nch, with inputs req[NCH], en, ptr, and outputs gnt_onehot and gnt_idx; purely combinational.
- The pipeline, decode and counters stay in dps_dec_arb.

Test Plan:
- Reset, then ch0 sends 29'h0000001 with out_ready=1 → out_valid at the 2nd edge after accept, out_data=1, out_ch=0, acc_cnt=1.
- ch2 sends 29'h0 → out_data=0, out_ch=2. Separately, ch1 sends only bit 28 set → out_data=`FNS29; then only bit 27 set → out_data=2*`FNS28.
- All 4 channels hold valid for 8 cycles with out_ready=1 → grant order 0,1,2,3,0,1,2,3; one in_ready per cycle; 8 outputs back-to-back; acc_cnt=8.
- Fill the pipeline, then hold out_ready=0 for 5 cycles → out_data/out_ch stable, in_ready=0 while S1 is full, no loss; on release, 2 queued words emerge in order.
- Assert rst with both stages full → next cycle out_valid=0, rr_ptr=0, acc_cnt=0; the next request from ch3 alone is granted and decoded correctly.
- With DPS_DEC_FPCHK_EN, send 29'h0000005 (101) → out_err=1; send 29'h0000003 → out_err=0. Without the macro, out_err=0 for both.

Source files
------------

// File: rtl/dps_pkg.sv
// dps_pkg: shared constants and decode helper for the 29-bit DPS
// (Fibonacci-numeral-system) codeword decoder.
// Weights use F(1)=F(2)=1, so the full-scale sum (1,664,079) fits in 21 bits.
package dps_pkg;

    localparam int CW = 29;
    localparam int DW = 21;

    typedef logic [DW-1:0] dw_t;
    typedef logic [CW-1:0] cw_t;

    // W[i] = F(i+1) for i=0..26, W[27] = 2*F(28), W[28] = F(29)
    localparam dw_t W [CW] = '{
        21'd1,      21'd1,      21'd2,      21'd3,      21'd5,
        21'd8,      21'd13,     21'd21,     21'd34,     21'd55,
        21'd89,     21'd144,    21'd233,    21'd377,    21'd610,
        21'd987,    21'd1597,   21'd2584,   21'd4181,   21'd6765,
        21'd10946,  21'd17711,  21'd28657,  21'd46368,  21'd75025,
        21'd121393, 21'd196418, 21'd635622, 21'd514229
    };

    function automatic dw_t fns_decode(input cw_t code);
        dw_t acc;
        acc = '0;
        for (int i = 0; i < CW; i++) begin
            if (code[i]) acc = acc + W[i];
        end
        return acc;
    endfunction

endpackage

// File: rtl/dps_dec_arb_rr.sv
// rr_arb_nch: purely combinational round-robin arbiter. Searches req starting
// at ptr and wrapping modulo NCH; grants nothing while en is low.
module rr_arb_nch #(
    parameter int NCH = 4,
    parameter int CHW = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic           en,
    input  logic [CHW-1:0] ptr,
    output logic [NCH-1:0] gnt_onehot,
    output logic [CHW-1:0] gnt_idx
);

    logic found;

    // First requesting channel at or after ptr wins
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (en && !found && req[(int'(ptr) + k) % NCH]) begin
                found                                = 1'b1;
                gnt_onehot[(int'(ptr) + k) % NCH]    = 1'b1;
                gnt_idx                              = CHW'((int'(ptr) + k) % NCH);
            end
        end
    end

endmodule

// File: rtl/dps_dec_arb.sv
// dps_dec_arb: one DPS codeword decoder shared by NCH channels through a
// round-robin arbiter, feeding a 2-stage elastic pipeline (S1: codeword and
// tag, S2: decoded word). Define DPS_DEC_FPCHK_EN to enable the forbidden
// 010/101 pattern check on out_err; otherwise out_err stays 0.
module dps_dec_arb
    import dps_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CHW = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*CW-1:0] in_code,
    input  logic [NCH-1:0]    in_valid,
    output logic [NCH-1:0]    in_ready,
    output logic [DW-1:0]     out_data,
    output logic [CHW-1:0]    out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_err,
    output logic [15:0]       acc_cnt
);

    logic           s1_v, s2_v;
    logic [CW-1:0]  code_q;
    logic [CHW-1:0] ch_q;
    logic [CHW-1:0] rr_ptr;
    logic           adv1, adv2;
    logic [NCH-1:0] gnt;
    logic [CHW-1:0] gnt_idx;
    logic [CHW-1:0] ptr_next;
    logic           chk;

    assign adv2 = !s2_v || out_ready;
    assign adv1 = !s1_v || adv2;

    rr_arb_nch #(.NCH(NCH), .CHW(CHW)) u_arb (
        .req        (in_valid),
        .en         (adv1 && !rst),
        .ptr        (rr_ptr),
        .gnt_onehot (gnt),
        .gnt_idx    (gnt_idx)
    );

    assign in_ready  = gnt;
    assign out_valid = s2_v;
    assign ptr_next  = (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef DPS_DEC_FPCHK_EN
    // Flag any isolated bit or isolated hole (010 / 101) in the held codeword
    always_comb begin
        chk = 1'b0;
        for (int i = 0; i < CW - 2; i++) begin
            if (code_q[i +: 3] == 3'b010 || code_q[i +: 3] == 3'b101) chk = 1'b1;
        end
    end
`else
    assign chk = 1'b0;
`endif

    // Arbitration into S1, decode into S2, and the accept counter
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v     <= 1'b0;
            s2_v     <= 1'b0;
            code_q   <= '0;
            ch_q     <= '0;
            out_data <= '0;
            out_ch   <= '0;
            out_err  <= 1'b0;
            rr_ptr   <= '0;
            acc_cnt  <= '0;
        end else begin
            if (adv1) begin
                if (|gnt) begin
                    code_q  <= in_code[int'(gnt_idx) * CW +: CW];
                    ch_q    <= gnt_idx;
                    s1_v    <= 1'b1;
                    rr_ptr  <= ptr_next;
                    acc_cnt <= acc_cnt + 16'd1;
                end else begin
                    s1_v    <= 1'b0;
                end
            end
            if (adv2) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    out_data <= fns_decode(code_q);
                    out_ch   <= ch_q;
                    out_err  <= chk;
                end
            end
        end
    end

endmodule

// File: tb/tb_dps_dec_arb.sv
// tb_dps_dec_arb: directed plus randomized bench for dps_dec_arb, checked
// against a transaction-level model (FIFO of in-flight words, RR pointer).
module tb_dps_dec_arb;

    localparam int NCH = 4;
    localparam int CHW = 2;
    localparam int CW  = 29;
    localparam int DW  = 21;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH*CW-1:0] in_code;
    logic [NCH-1:0]    in_valid;
    logic [NCH-1:0]    in_ready;
    logic [DW-1:0]     out_data;
    logic [CHW-1:0]    out_ch;
    logic              out_valid;
    logic              out_ready;
    logic              out_err;
    logic [15:0]       acc_cnt;

    always #5 clk = ~clk;

    dps_dec_arb #(.NCH(NCH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_code   (in_code),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_err   (out_err),
        .acc_cnt   (acc_cnt)
    );

    typedef struct {
        int d;
        int ch;
        bit e;
        int stamp;
    } item_t;

    item_t q[$];
    int ptr_m, cnt_m, edges;
    int last_d, last_ch;
    bit last_e;
    int n_cmp, n_fail;

    function automatic int fib(input int n);
        int a, b, t;
        a = 1; b = 1;
        for (int i = 2; i < n; i++) begin
            t = a + b; a = b; b = t;
        end
        return (n <= 2) ? 1 : b;
    endfunction

    function automatic int ref_decode(input logic [CW-1:0] c);
        int s;
        s = 0;
        for (int i = 0; i < CW; i++) begin
            if (c[i]) begin
                if (i < 27)       s += fib(i + 1);
                else if (i == 27) s += 2 * fib(28);
                else              s += fib(29);
            end
        end
        return s;
    endfunction

    function automatic bit ref_err(input logic [CW-1:0] c);
        bit e;
        e = 1'b0;
`ifdef DPS_DEC_FPCHK_EN
        for (int i = 0; i + 2 < CW; i++) begin
            if (c[i] != c[i+1] && c[i+1] != c[i+2]) e = 1'b1;
        end
`endif
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int k, input bit v, input logic [CW-1:0] c);
        in_valid[k]        = v;
        in_code[k*CW +: CW] = c;
    endtask

    // One clock: compare DUT against the model, then advance the model past the edge
    task automatic cycle();
        bit ov, can;
        int g;
        logic [NCH-1:0] exp_rdy;
        item_t it;
        logic [CW-1:0] c;
        #2;
        ov  = (q.size() > 0) && (q[0].stamp < edges);
        can = (q.size() < 2) || (ov && out_ready);
        g   = -1;
        if (can && !rst) begin
            for (int k = 0; k < NCH; k++) begin
                if (g < 0 && in_valid[(ptr_m + k) % NCH]) g = (ptr_m + k) % NCH;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        if (ov) begin
            last_d = q[0].d; last_ch = q[0].ch; last_e = q[0].e;
        end
        chk("in_ready",  32'(in_ready),  32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(ov));
        chk("out_data",  32'(out_data),  32'(last_d));
        chk("out_ch",    32'(out_ch),    32'(last_ch));
        chk("out_err",   32'(out_err),   32'(last_e));
        chk("acc_cnt",   32'(acc_cnt),   32'(cnt_m));
        if (g >= 0) c = in_code[g*CW +: CW];
        else        c = '0;
        @(posedge clk);
        edges++;
        if (rst) begin
            q.delete();
            ptr_m = 0; cnt_m = 0;
            last_d = 0; last_ch = 0; last_e = 1'b0;
        end else begin
            if (ov && out_ready) void'(q.pop_front());
            if (g >= 0) begin
                it.d = ref_decode(c); it.ch = g; it.e = ref_err(c); it.stamp = edges;
                q.push_back(it);
                ptr_m = (g + 1) % NCH;
                cnt_m = (cnt_m + 1) % 65536;
            end
        end
        #1;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; edges = 0;
        ptr_m = 0; cnt_m = 0; last_d = 0; last_ch = 0; last_e = 1'b0;
        rst = 1'b1; in_valid = '0; in_code = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        cycle();
        rst = 1'b0;
        cycle();

        // single words on specific channels
        set_ch(0, 1, 29'h0000001); cycle(); set_ch(0, 0, '0);
        repeat (3) cycle();
        set_ch(2, 1, 29'h0000000); cycle(); set_ch(2, 0, '0);
        repeat (3) cycle();
        set_ch(1, 1, 29'h1 << 28); cycle(); set_ch(1, 0, '0);
        repeat (3) cycle();
        set_ch(1, 1, 29'h1 << 27); cycle(); set_ch(1, 0, '0);
        repeat (3) cycle();

        // all channels requesting: round-robin at full rate
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < NCH; k++) set_ch(k, 1, CW'($urandom));
            cycle();
        end
        in_valid = '0;
        repeat (3) cycle();

        // fill the pipeline and stall the sink
        out_ready = 1'b0;
        for (int n = 0; n < 7; n++) begin
            for (int k = 0; k < NCH; k++) set_ch(k, 1, CW'($urandom));
            cycle();
        end
        in_valid = '0; out_ready = 1'b1;
        repeat (4) cycle();

        // reset with both stages occupied
        out_ready = 1'b0;
        set_ch(0, 1, 29'h00000A5); cycle(); cycle(); set_ch(0, 0, '0);
        rst = 1'b1; cycle(); rst = 1'b0; out_ready = 1'b1;
        cycle();
        set_ch(3, 1, 29'h1234567); cycle(); set_ch(3, 0, '0);
        repeat (3) cycle();

        // forbidden-pattern words
        set_ch(0, 1, 29'h0000005); cycle(); set_ch(0, 0, '0);
        repeat (2) cycle();
        set_ch(0, 1, 29'h0000003); cycle(); set_ch(0, 0, '0);
        repeat (2) cycle();

        // randomized traffic with random backpressure and rare resets
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NCH; k++) begin
                set_ch(k, 1'($urandom_range(0, 1)), CW'($urandom));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0; in_valid = '0; out_ready = 1'b1;
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
